int_issue_queue: RTL and testbench

- Receiving end of the dispatch-to-integer-queue write interface; one instance per integer ALU lane (A and B).
- Accepts one decoded instruction per cycle from the dispatch unit and holds it until both source operands are valid.
- Snoops the CDB to wake up waiting operands.
- Issues the oldest ready entry to the integer ALU under a request/grant handshake; drives the full flag back to dispatch.

---
 rtl/int_issue_queue_if.sv | 48 ++++
 rtl/int_issue_queue.sv | 143 ++++++++++++++
 tb/tb_int_issue_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_issue_queue_if.sv
// rtl/int_issue_queue_if.sv - dispatch, CDB and issue signals of one integer issue queue lane
interface int_issue_queue_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic              dispatch_en_integer;
  logic [DATA_W-1:0] dispatch_rs_data;
  logic              dispatch_rs_data_valid;
  logic [TAG_W-1:0]  dispatch_rs_tag;
  logic [DATA_W-1:0] dispatch_rt_data;
  logic              dispatch_rt_data_valid;
  logic [TAG_W-1:0]  dispatch_rt_tag;
  logic [TAG_W-1:0]  dispatch_rd_tag;
  logic [3:0]        dispatch_opcode;
  logic [4:0]        dispatch_shfamt;
  logic              issueque_integer_full;
  logic              Cdb_valid;
  logic [TAG_W-1:0]  Cdb_rd_tag;
  logic [DATA_W-1:0] Cdb_data;
  logic              flush;
  logic              issueque_int_ready;
  logic              issueblk_int_grant;
  logic [DATA_W-1:0] issueque_int_rs_data;
  logic [DATA_W-1:0] issueque_int_rt_data;
  logic [3:0]        issueque_int_opcode;
  logic [4:0]        issueque_int_shfamt;
  logic [TAG_W-1:0]  issueque_int_rd_tag;

  // Dispatch / CDB / ALU side
  modport master (
    output dispatch_en_integer, dispatch_rs_data, dispatch_rs_data_valid, dispatch_rs_tag,
    output dispatch_rt_data, dispatch_rt_data_valid, dispatch_rt_tag, dispatch_rd_tag,
    output dispatch_opcode, dispatch_shfamt, Cdb_valid, Cdb_rd_tag, Cdb_data, flush,
    output issueblk_int_grant,
    input  issueque_integer_full, issueque_int_ready, issueque_int_rs_data,
    input  issueque_int_rt_data, issueque_int_opcode, issueque_int_shfamt, issueque_int_rd_tag
  );

  // Issue queue side
  modport slave (
    input  dispatch_en_integer, dispatch_rs_data, dispatch_rs_data_valid, dispatch_rs_tag,
    input  dispatch_rt_data, dispatch_rt_data_valid, dispatch_rt_tag, dispatch_rd_tag,
    input  dispatch_opcode, dispatch_shfamt, Cdb_valid, Cdb_rd_tag, Cdb_data, flush,
    input  issueblk_int_grant,
    output issueque_integer_full, issueque_int_ready, issueque_int_rs_data,
    output issueque_int_rt_data, issueque_int_opcode, issueque_int_shfamt, issueque_int_rd_tag
  );
endinterface

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - compacting age-ordered integer issue queue with CDB wakeup
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input logic            clock,
  input logic            reset,
  int_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic              rs_valid;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rt_data;
    logic              rt_valid;
    logic [TAG_W-1:0]  rt_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic [3:0]        opcode;
    logic [4:0]        shfamt;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           q_nxt [DEPTH];
  entry_t           new_entry;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    wr_pos;
  logic [DEPTH-1:0] ready_vec;
  logic [IW-1:0]    sel;
  logic             any_ready;
  logic             full;
  logic             do_issue;
  logic             do_write;

  assign full     = (count == CW'(DEPTH));
  assign do_issue = any_ready & bus.issueblk_int_grant;
  assign do_write = bus.dispatch_en_integer & ~full;
  // A same-edge issue compacts the queue first, so the new entry lands one slot lower
  assign wr_pos    = count - CW'(do_issue);
  assign count_nxt = count + CW'(do_write) - CW'(do_issue);
  assign bus.issueque_integer_full = full;

  // Oldest-first select: lowest-index slot with both operands valid
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    ready_vec = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_vec[i] = q[i].valid & q[i].rs_valid & q[i].rt_valid;
      if (ready_vec[i]) begin
        sel       = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  // Incoming entry, with operands captured straight off a matching CDB broadcast
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rs_tag   = bus.dispatch_rs_tag;
    new_entry.rt_tag   = bus.dispatch_rt_tag;
    new_entry.rd_tag   = bus.dispatch_rd_tag;
    new_entry.opcode   = bus.dispatch_opcode;
    new_entry.shfamt   = bus.dispatch_shfamt;
    new_entry.rs_valid = bus.dispatch_rs_data_valid;
    new_entry.rs_data  = bus.dispatch_rs_data;
    new_entry.rt_valid = bus.dispatch_rt_data_valid;
    new_entry.rt_data  = bus.dispatch_rt_data;
    if (!bus.dispatch_rs_data_valid && bus.Cdb_valid && bus.dispatch_rs_tag == bus.Cdb_rd_tag) begin
      new_entry.rs_valid = 1'b1;
      new_entry.rs_data  = bus.Cdb_data;
    end
    if (!bus.dispatch_rt_data_valid && bus.Cdb_valid && bus.dispatch_rt_tag == bus.Cdb_rd_tag) begin
      new_entry.rt_valid = 1'b1;
      new_entry.rt_data  = bus.Cdb_data;
    end
  end

  // Next queue image: compact out the issued slot, wake operands from the CDB, then append
  always_comb begin
    for (int i = 0; i < DEPTH; i++) q_nxt[i] = q[i];
    if (do_issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) q_nxt[i] = q[i + 1];
      end
      q_nxt[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.Cdb_valid && q_nxt[i].valid) begin
        if (!q_nxt[i].rs_valid && q_nxt[i].rs_tag == bus.Cdb_rd_tag) begin
          q_nxt[i].rs_valid = 1'b1;
          q_nxt[i].rs_data  = bus.Cdb_data;
        end
        if (!q_nxt[i].rt_valid && q_nxt[i].rt_tag == bus.Cdb_rd_tag) begin
          q_nxt[i].rt_valid = 1'b1;
          q_nxt[i].rt_data  = bus.Cdb_data;
        end
      end
    end
    if (do_write) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == int'(wr_pos)) q_nxt[i] = new_entry;
      end
    end
  end

  // State update; flush beats every other same-edge action
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt;
    end
  end

  // Issue port shows the selected entry, forced to zero when nothing is ready
  always_comb begin
    bus.issueque_int_ready   = any_ready;
    bus.issueque_int_rs_data = '0;
    bus.issueque_int_rt_data = '0;
    bus.issueque_int_opcode  = '0;
    bus.issueque_int_shfamt  = '0;
    bus.issueque_int_rd_tag  = '0;
    if (any_ready) begin
      bus.issueque_int_rs_data = q[sel].rs_data;
      bus.issueque_int_rt_data = q[sel].rt_data;
      bus.issueque_int_opcode  = q[sel].opcode;
      bus.issueque_int_shfamt  = q[sel].shfamt;
      bus.issueque_int_rd_tag  = q[sel].rd_tag;
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - scoreboard bench for int_issue_queue
module tb_int_issue_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;

  int_issue_queue_if #(.TAG_W(5), .DATA_W(32)) bus ();

  int_issue_queue #(.DEPTH(4), .TAG_W(5), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic [4:0]  sh;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_en_integer    = 1'b0;
    bus.dispatch_rs_data       = '0;
    bus.dispatch_rs_data_valid = 1'b0;
    bus.dispatch_rs_tag        = '0;
    bus.dispatch_rt_data       = '0;
    bus.dispatch_rt_data_valid = 1'b0;
    bus.dispatch_rt_tag        = '0;
    bus.dispatch_rd_tag        = '0;
    bus.dispatch_opcode        = '0;
    bus.dispatch_shfamt        = '0;
    bus.Cdb_valid              = 1'b0;
    bus.Cdb_rd_tag             = '0;
    bus.Cdb_data               = '0;
    bus.flush                  = 1'b0;
    bus.issueblk_int_grant     = 1'b0;
  endtask

  // Opcode and shift amount are derived from rd so each entry is distinguishable
  task automatic drive_dispatch(input logic [4:0] rd, input logic [31:0] rs, input logic rsv,
                                input logic [4:0] rstag, input logic [31:0] rt, input logic rtv,
                                input logic [4:0] rttag);
    bus.dispatch_en_integer    = 1'b1;
    bus.dispatch_rd_tag        = rd;
    bus.dispatch_rs_data       = rs;
    bus.dispatch_rs_data_valid = rsv;
    bus.dispatch_rs_tag        = rstag;
    bus.dispatch_rt_data       = rt;
    bus.dispatch_rt_data_valid = rtv;
    bus.dispatch_rt_tag        = rttag;
    bus.dispatch_opcode        = rd[3:0] ^ 4'hA;
    bus.dispatch_shfamt        = rd + 5'd3;
  endtask

  task automatic write_entry(input logic [4:0] rd, input logic [31:0] rs, input logic rsv,
                             input logic [4:0] rstag, input logic [31:0] rt, input logic rtv,
                             input logic [4:0] rttag);
    drive_dispatch(rd, rs, rsv, rstag, rt, rtv, rttag);
    tick();
    bus.dispatch_en_integer = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    e.rd = rd;
    e.rs = rs;
    e.rt = rt;
    e.op = rd[3:0] ^ 4'hA;
    e.sh = rd + 5'd3;
    exp_q.push_back(e);
  endtask

  task automatic write_ready(input logic [4:0] rd, input logic push);
    write_entry(rd, 32'h1000 + 32'(rd), 1'b1, 5'd0, 32'h2000 + 32'(rd), 1'b1, 5'd0);
    if (push) push_exp(rd, 32'h1000 + 32'(rd), 32'h2000 + 32'(rd));
  endtask

  // Compare the presented entry with the scoreboard head, then grant it
  task automatic issue_check(input string name);
    exp_t e;
    check({name, "_ready"}, 64'(bus.issueque_int_ready), 64'd1);
    check({name, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({name, "_rd_tag"}, 64'(bus.issueque_int_rd_tag), 64'(e.rd));
      check({name, "_rs_data"}, 64'(bus.issueque_int_rs_data), 64'(e.rs));
      check({name, "_rt_data"}, 64'(bus.issueque_int_rt_data), 64'(e.rt));
      check({name, "_opcode"}, 64'(bus.issueque_int_opcode), 64'(e.op));
      check({name, "_shfamt"}, 64'(bus.issueque_int_shfamt), 64'(e.sh));
    end
    bus.issueblk_int_grant = 1'b1;
    tick();
    bus.issueblk_int_grant = 1'b0;
  endtask

  task automatic check_empty(input string name);
    check({name, "_ready0"}, 64'(bus.issueque_int_ready), 64'd0);
    check({name, "_full0"}, 64'(bus.issueque_integer_full), 64'd0);
    check({name, "_rd_out0"}, 64'(bus.issueque_int_rd_tag), 64'd0);
    check({name, "_rs_out0"}, 64'(bus.issueque_int_rs_data), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_empty("reset");

    // Fill, drop a write while full, drain in order
    for (int i = 1; i <= 4; i++) begin
      write_ready(5'(i), 1'b1);
      check($sformatf("fill%0d_full", i), 64'(bus.issueque_integer_full), 64'(i == 4));
    end
    write_ready(5'd5, 1'b0);
    check("full_drop_full", 64'(bus.issueque_integer_full), 64'd1);
    bus.issueblk_int_grant = 1'b0;
    tick();
    check("stable_no_grant", 64'(bus.issueque_int_rd_tag), 64'd1);
    for (int i = 1; i <= 4; i++) issue_check($sformatf("drain%0d", i));
    check_empty("drained");

    // CDB wakeup of rs
    write_entry(5'd3, 32'h0, 1'b0, 5'd7, 32'h2003, 1'b1, 5'd0);
    push_exp(5'd3, 32'h55, 32'h2003);
    check("wait_rs_ready", 64'(bus.issueque_int_ready), 64'd0);
    bus.Cdb_valid  = 1'b1;
    bus.Cdb_rd_tag = 5'd7;
    bus.Cdb_data   = 32'h55;
    check("no_same_cycle_ready", 64'(bus.issueque_int_ready), 64'd0);
    tick();
    bus.Cdb_valid = 1'b0;
    issue_check("wake_rs");
    check_empty("wake_rs_done");

    // Younger ready entry issues ahead of a waiting older one
    write_entry(5'd1, 32'h1001, 1'b1, 5'd0, 32'h0, 1'b0, 5'd9);
    write_ready(5'd2, 1'b1);
    issue_check("ooo_young");
    check("ooo_old_wait", 64'(bus.issueque_int_ready), 64'd0);
    bus.Cdb_valid  = 1'b1;
    bus.Cdb_rd_tag = 5'd9;
    bus.Cdb_data   = 32'h99;
    tick();
    bus.Cdb_valid = 1'b0;
    push_exp(5'd1, 32'h1001, 32'h99);
    issue_check("ooo_old");
    check_empty("ooo_done");

    // Dispatch bypass from a same-cycle CDB broadcast
    bus.Cdb_valid  = 1'b1;
    bus.Cdb_rd_tag = 5'd4;
    bus.Cdb_data   = 32'hABCD;
    write_entry(5'd6, 32'h1006, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4);
    bus.Cdb_valid = 1'b0;
    push_exp(5'd6, 32'h1006, 32'hABCD);
    issue_check("bypass");
    check_empty("bypass_done");

    // Full queue: grant and write in the same edge drops the write
    for (int i = 1; i <= 4; i++) write_ready(5'(i), 1'b1);
    drive_dispatch(5'd9, 32'h1009, 1'b1, 5'd0, 32'h2009, 1'b1, 5'd0);
    issue_check("full_grant");
    bus.dispatch_en_integer = 1'b0;
    check("full_grant_full", 64'(bus.issueque_integer_full), 64'd0);
    write_ready(5'd10, 1'b1);
    check("refill_full", 64'(bus.issueque_integer_full), 64'd1);
    for (int i = 0; i < 4; i++) issue_check($sformatf("refill_drain%0d", i));
    check_empty("refill_done");

    // Write and issue together on a partly filled queue: new entry goes to the back
    write_ready(5'd11, 1'b1);
    write_ready(5'd12, 1'b1);
    drive_dispatch(5'd13, 32'h100D, 1'b1, 5'd0, 32'h200D, 1'b1, 5'd0);
    issue_check("wr_iss");
    bus.dispatch_en_integer = 1'b0;
    push_exp(5'd13, 32'h100D, 32'h200D);
    issue_check("wr_iss_a");
    issue_check("wr_iss_b");
    check_empty("wr_iss_done");

    // Flush beats a same-edge write
    for (int i = 1; i <= 3; i++) write_ready(5'(i), 1'b0);
    drive_dispatch(5'd8, 32'h1008, 1'b1, 5'd0, 32'h2008, 1'b1, 5'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.dispatch_en_integer = 1'b0;
    check_empty("flush");
    write_ready(5'd14, 1'b1);
    issue_check("post_flush");
    check_empty("post_flush_done");

    // Reset mid-fill
    write_ready(5'd1, 1'b0);
    write_ready(5'd2, 1'b0);
    drive_dispatch(5'd3, 32'h1003, 1'b1, 5'd0, 32'h2003, 1'b1, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.dispatch_en_integer = 1'b0;
    check_empty("mid_reset");
    for (int i = 20; i < 23; i++) write_ready(5'(i), 1'b1);
    check("post_reset_3_full", 64'(bus.issueque_integer_full), 64'd0);
    write_ready(5'd23, 1'b1);
    check("post_reset_4_full", 64'(bus.issueque_integer_full), 64'd1);
    for (int i = 0; i < 4; i++) issue_check($sformatf("post_reset_drain%0d", i));
    check_empty("post_reset_done");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
